linkinit_handshake: RTL and testbench
=====================================

Name: linkinit_handshake

Overview:
- LTSM LINKINIT-entry stage, directly downstream of the mainband training stage.
- Enabled once mainband training reports done.
- Performs the sideband LINKINIT active request/response exchange with the link partner, supervised by a timeout.
- Asserts done_o when the handshake completes in both directions; the LTSM then enters ACTIVE.

Parameters:
- TIMEOUT_CYCLES, 800000, clk_100MHz cycles before timeout (8 ms); counter width $clog2(TIMEOUT_CYCLES).
- TX_DATA_VALUE, 64'h0, value driven on SB_TX_dataBus_o with every message.

Ports:
- clk_100MHz  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- enable_i  in  1  stage enable from LTSM; level-sensitive.
- done_o  out  1  handshake complete; held while enable_i=1.
- timeout_o  out  1  sticky timeout flag; held while enable_i=1.
- reset_state_timeout_counter_o  out  1  one-cycle pulse on the first enabled cycle.
- SB_TX_msg_o  out  SB_msg_t  message to send.
- SB_TX_dataBus_o  out  64  message payload.
- SB_TX_msg_valid_o  out  1  TX message valid.
- SB_TX_msg_sendNextFlag_i  in  1  sideband TX accepted the current message this cycle.
- SB_RX_msg_i  in  SB_msg_t  received message.
- SB_RX_dataBus_i  in  64  received payload (ignored).
- SB_RX_msg_req_o  out  1  ready to consume an RX message.
- SB_RX_msg_valid_i  in  1  RX message present.

Behaviour:
- Reset values: all outputs 0. SB_TX_msg_o = LINKINIT_ACTIVE_REQ encoding; this encoding and LINKINIT_ACTIVE_RESP are members of SB_msg_t in SB_codex_pkg. All flags and counter are 0.
- enable_i=0 at any time, including mid-handshake: on the next edge, return to S_IDLE, clear all flags and the counter, and drive outputs to reset values. No partial message stays valid.
- Internal flags:
  - req_sent: local REQ accepted.
  - rem_req: partner REQ received.
  - resp_sent: local RESP accepted.
  - resp_rcvd: partner RESP received.
- States:
  - S_IDLE: on enable_i=1, go to S_SEND_REQ and pulse reset_state_timeout_counter_o for 1 cycle.
  - S_SEND_REQ: SB_TX_msg_valid_o=1, msg=REQ. On sendNextFlag=1, set req_sent and go to S_WAIT. msg and valid stay stable until accepted.
  - S_WAIT: if rem_req=1 and resp_sent=0, go to S_SEND_RESP. If resp_sent=1 and resp_rcvd=1, go to S_DONE.
  - S_SEND_RESP: valid=1, msg=RESP. On sendNextFlag=1, set resp_sent and go to S_WAIT.
  - S_DONE: done_o=1, SB_RX_msg_req_o=0; stay until enable_i=0.
  - S_TIMEOUT: timeout_o=1, valid=0, req=0; stay until enable_i=0.
- RX:
  - SB_RX_msg_req_o=1 in S_SEND_REQ, S_WAIT and S_SEND_RESP.
  - A message is consumed in a cycle where req_o=1 and valid_i=1.
  - REQ consumed: set rem_req. A duplicate REQ after rem_req is dropped silently.
  - RESP consumed with req_sent=1: set resp_rcvd.
  - RESP with req_sent=0, or any other message: unexpected; consume and drop.
  - An RX REQ arriving in S_SEND_REQ is recorded; RESP is sent only after the local REQ is accepted. REQ always goes out before RESP.
- Flag updates and state transitions in the same cycle: the flag update is visible to the next-state decision one cycle later. Done therefore follows the last of resp_sent/resp_rcvd by exactly 1 cycle.
- Latency with a zero-wait sideband (sendNextFlag high when valid), partner REQ already seen and RESP arriving promptly: done_o at cycle 5 after enable_i rises.
- Timeout:
  - Counter increments each enabled cycle in states other than S_IDLE, S_DONE and S_TIMEOUT.
  - On reaching TIMEOUT_CYCLES-1, go to S_TIMEOUT. The counter saturates there and does not wrap.
  - If completion and the terminal count occur in the same cycle, S_DONE wins.

Optional Feature:
- Macro LINKINIT_ERRCNT_EN.
- When defined: extra output port unexpected_cnt_o (out, 8), an 8-bit saturating count of unexpected RX messages. It stays at 8'hFF once reached, and is cleared by reset or enable_i=0.
- When undefined: the port and counter do not exist; unexpected messages are still consumed and dropped.

Test Plan:
- Zero-wait sideband, partner REQ at cycle 2 and RESP at cycle 4 after enable -> TX sends REQ then RESP; done_o=1 by cycle 6 and stays 1; timeout_o=0.
- Partner REQ arrives while local REQ is stalled (sendNextFlag=0 for 10 cycles) -> REQ valid and stable for 10 cycles; RESP sent only after REQ accepted; done_o=1.
- TIMEOUT_CYCLES=64, partner silent -> timeout_o=1 at cycle 64 after enable; valid_o=0; done_o never 1.
- enable_i dropped after REQ is accepted, then re-raised -> all outputs 0 one cycle after drop; re-raise pulses reset_state_timeout_counter_o and REQ is sent again.
- RESP received before local REQ accepted, then proper REQ/RESP -> early RESP ignored (with LINKINIT_ERRCNT_EN, unexpected_cnt_o=1); done_o only after a later RESP.
- 300 unexpected messages with LINKINIT_ERRCNT_EN -> unexpected_cnt_o=8'hFF, no wrap.

Source files
------------

// File: rtl/linkinit_handshake.sv
// LTSM LINKINIT-entry stage: sideband LINKINIT active REQ/RESP exchange
// with the link partner, supervised by a saturating timeout counter.
// Ports: clk_100MHz, reset (async active-low), enable_i, done_o, timeout_o,
//   reset_state_timeout_counter_o, SB_TX_* (msg/data/valid, sendNextFlag_i),
//   SB_RX_* (msg/data/valid in, msg_req_o out).
// Optional: define LINKINIT_ERRCNT_EN to add unexpected_cnt_o [7:0].

package SB_codex_pkg;
    typedef enum logic [7:0] {
        SB_MSG_NONE          = 8'h00,
        MBTRAIN_DONE_REQ     = 8'h31,
        MBTRAIN_DONE_RESP    = 8'h32,
        LINKINIT_ACTIVE_REQ  = 8'h41,
        LINKINIT_ACTIVE_RESP = 8'h42
    } SB_msg_t;
endpackage

module linkinit_handshake
    import SB_codex_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 800000,
    parameter logic [63:0] TX_DATA_VALUE  = 64'h0
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        enable_i,
    output logic        done_o,
    output logic        timeout_o,
    output logic        reset_state_timeout_counter_o,
    output SB_msg_t     SB_TX_msg_o,
    output logic [63:0] SB_TX_dataBus_o,
    output logic        SB_TX_msg_valid_o,
    input  logic        SB_TX_msg_sendNextFlag_i,
    input  SB_msg_t     SB_RX_msg_i,
    input  logic [63:0] SB_RX_dataBus_i,
    output logic        SB_RX_msg_req_o,
    input  logic        SB_RX_msg_valid_i
`ifdef LINKINIT_ERRCNT_EN
    ,
    output logic [7:0]  unexpected_cnt_o
`endif
);

    localparam int CW =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_REQ,
        S_WAIT,
        S_SEND_RESP,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_sent_q, req_sent_d;
    logic          rem_req_q, rem_req_d;
    logic          resp_sent_q, resp_sent_d;
    logic          resp_rcvd_q, resp_rcvd_d;
    logic          done_q, done_d;
    logic          tmo_q, tmo_d;
    logic          pulse_q, pulse_d;
    SB_msg_t       msg_q, msg_d;
    logic [63:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          rx_req_q, rx_req_d;
`ifdef LINKINIT_ERRCNT_EN
    logic [7:0]    err_q, err_d;
`endif

    logic cons, busy, fin;
    logic unused_rx;

    assign unused_rx = ^SB_RX_dataBus_i;
    assign cons = rx_req_q & SB_RX_msg_valid_i;
    assign busy = (state_q == S_SEND_REQ) || (state_q == S_WAIT) ||
                  (state_q == S_SEND_RESP);
    // Completion uses the registered flags, so done lags the last
    // flag update by one cycle.
    assign fin  = (state_q == S_WAIT) && resp_sent_q && resp_rcvd_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_sent_d  = req_sent_q;
        rem_req_d   = rem_req_q;
        resp_sent_d = resp_sent_q;
        resp_rcvd_d = resp_rcvd_q;
        done_d      = done_q;
        tmo_d       = tmo_q;
        pulse_d     = 1'b0;
        msg_d       = msg_q;
        valid_d     = valid_q;
        rx_req_d    = rx_req_q;
`ifdef LINKINIT_ERRCNT_EN
        err_d       = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                state_d     = S_SEND_REQ;
                pulse_d     = 1'b1;
                valid_d     = 1'b1;
                msg_d       = LINKINIT_ACTIVE_REQ;
                rx_req_d    = 1'b1;
                cnt_d       = '0;
            end
            S_SEND_REQ: begin
                if (SB_TX_msg_sendNextFlag_i) begin
                    req_sent_d = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fin) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    rx_req_d = 1'b0;
                end else if (rem_req_q && !resp_sent_q) begin
                    state_d = S_SEND_RESP;
                    valid_d = 1'b1;
                    msg_d   = LINKINIT_ACTIVE_RESP;
                end
            end
            S_SEND_RESP: begin
                if (SB_TX_msg_sendNextFlag_i) begin
                    resp_sent_d = 1'b1;
                    valid_d     = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_DONE, S_TIMEOUT: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Completion takes priority over the terminal count.
        if (busy && !fin) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == LAST) begin
                state_d  = S_TIMEOUT;
                tmo_d    = 1'b1;
                valid_d  = 1'b0;
                rx_req_d = 1'b0;
            end
        end

        if (cons) begin
            if (SB_RX_msg_i == LINKINIT_ACTIVE_REQ) begin
                rem_req_d = 1'b1;
            end else if (SB_RX_msg_i == LINKINIT_ACTIVE_RESP &&
                         req_sent_q) begin
                resp_rcvd_d = 1'b1;
            end else begin
`ifdef LINKINIT_ERRCNT_EN
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
            end
        end

        if (!enable_i) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            req_sent_d  = 1'b0;
            rem_req_d   = 1'b0;
            resp_sent_d = 1'b0;
            resp_rcvd_d = 1'b0;
            done_d      = 1'b0;
            tmo_d       = 1'b0;
            pulse_d     = 1'b0;
            msg_d       = LINKINIT_ACTIVE_REQ;
            valid_d     = 1'b0;
            rx_req_d    = 1'b0;
`ifdef LINKINIT_ERRCNT_EN
            err_d       = 8'h00;
`endif
        end

        data_d = valid_d ? TX_DATA_VALUE : 64'h0;
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_sent_q  <= 1'b0;
            rem_req_q   <= 1'b0;
            resp_sent_q <= 1'b0;
            resp_rcvd_q <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            pulse_q     <= 1'b0;
            msg_q       <= LINKINIT_ACTIVE_REQ;
            data_q      <= 64'h0;
            valid_q     <= 1'b0;
            rx_req_q    <= 1'b0;
`ifdef LINKINIT_ERRCNT_EN
            err_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_sent_q  <= req_sent_d;
            rem_req_q   <= rem_req_d;
            resp_sent_q <= resp_sent_d;
            resp_rcvd_q <= resp_rcvd_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            pulse_q     <= pulse_d;
            msg_q       <= msg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            rx_req_q    <= rx_req_d;
`ifdef LINKINIT_ERRCNT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign done_o                        = done_q;
    assign timeout_o                     = tmo_q;
    assign reset_state_timeout_counter_o = pulse_q;
    assign SB_TX_msg_o                   = msg_q;
    assign SB_TX_dataBus_o               = data_q;
    assign SB_TX_msg_valid_o             = valid_q;
    assign SB_RX_msg_req_o               = rx_req_q;
`ifdef LINKINIT_ERRCNT_EN
    assign unexpected_cnt_o              = err_q;
`endif

endmodule

// File: tb/tb_linkinit_handshake.sv
// Randomized bench for linkinit_handshake against a flag-level model.
// Honors LINKINIT_ERRCNT_EN when the design is built with it.

module tb_linkinit_handshake;
    import SB_codex_pkg::*;

    localparam int          T   = 320;
    localparam logic [63:0] TXV = 64'hA5A5_0123_4567_89AB;

    logic        clk_100MHz = 1'b0;
    logic        reset      = 1'b0;
    logic        enable_i   = 1'b0;
    logic        snf        = 1'b0;
    logic        rxv        = 1'b0;
    SB_msg_t     rxm        = SB_MSG_NONE;
    logic [63:0] rxd        = 64'h0;

    logic        done_o, timeout_o, pulse_o, valid_o, rxreq_o;
    SB_msg_t     msg_o;
    logic [63:0] data_o;
`ifdef LINKINIT_ERRCNT_EN
    logic [7:0]  errcnt_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    linkinit_handshake #(
        .TIMEOUT_CYCLES(T),
        .TX_DATA_VALUE (TXV)
    ) dut (
        .clk_100MHz                   (clk_100MHz),
        .reset                        (reset),
        .enable_i                     (enable_i),
        .done_o                       (done_o),
        .timeout_o                    (timeout_o),
        .reset_state_timeout_counter_o(pulse_o),
        .SB_TX_msg_o                  (msg_o),
        .SB_TX_dataBus_o              (data_o),
        .SB_TX_msg_valid_o            (valid_o),
        .SB_TX_msg_sendNextFlag_i     (snf),
        .SB_RX_msg_i                  (rxm),
        .SB_RX_dataBus_i              (rxd),
        .SB_RX_msg_req_o              (rxreq_o),
        .SB_RX_msg_valid_i            (rxv)
`ifdef LINKINIT_ERRCNT_EN
        ,
        .unexpected_cnt_o             (errcnt_o)
`endif
    );

    // Model: started flag, what is on offer (0 none, 1 REQ, 2 RESP),
    // the four handshake flags, terminal flags and the elapsed count.
    bit      m_on, m_pulse, m_done, m_tmo;
    bit      m_rs, m_pr, m_ps, m_rr;
    int      m_tx, m_cnt, m_err;
    SB_msg_t m_msg = LINKINIT_ACTIVE_REQ;

    task automatic check(string nm, logic [63:0] a, logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, a, e, $time);
        end
    endtask

    task automatic model_clear();
        m_on = 0; m_pulse = 0; m_done = 0; m_tmo = 0;
        m_rs = 0; m_pr = 0; m_ps = 0; m_rr = 0;
        m_tx = 0; m_cnt = 0; m_err = 0;
        m_msg = LINKINIT_ACTIVE_REQ;
    endtask

    task automatic model_step();
        bit n_pr, n_rr;
        if (!reset || !enable_i) begin
            model_clear();
        end else if (!m_on) begin
            m_on = 1; m_pulse = 1; m_tx = 1;
            m_msg = LINKINIT_ACTIVE_REQ; m_cnt = 0;
        end else begin
            m_pulse = 0;
            if (!m_done && !m_tmo) begin
                n_pr = m_pr;
                n_rr = m_rr;
                if (rxv) begin
                    if (rxm == LINKINIT_ACTIVE_REQ) n_pr = 1;
                    else if (rxm == LINKINIT_ACTIVE_RESP && m_rs) n_rr = 1;
                    else if (m_err < 255) m_err++;
                end
                if (m_tx == 0 && m_ps && m_rr) begin
                    m_done = 1;
                end else begin
                    if (m_tx != 0 && snf) begin
                        if (m_tx == 1) m_rs = 1;
                        else m_ps = 1;
                        m_tx = 0;
                    end else if (m_tx == 0 && m_pr && !m_ps) begin
                        m_tx = 2;
                        m_msg = LINKINIT_ACTIVE_RESP;
                    end
                    m_cnt++;
                    if (m_cnt == T - 1) begin
                        m_tmo = 1;
                        m_tx = 0;
                    end
                end
                m_pr = n_pr;
                m_rr = n_rr;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", valid_o, m_tx != 0);
        check("msg", msg_o, m_msg);
        check("data", data_o, (m_tx != 0) ? TXV : 64'h0);
        check("rx_req", rxreq_o, m_on && !m_done && !m_tmo);
        check("done", done_o, m_done);
        check("timeout", timeout_o, m_tmo);
        check("pulse", pulse_o, m_pulse);
`ifdef LINKINIT_ERRCNT_EN
        check("errcnt", errcnt_o, m_err[7:0]);
`endif
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        model_step();
        @(negedge clk_100MHz);
        compare_all();
    endtask

    task automatic drive(bit s, bit v, SB_msg_t m);
        snf = s;
        rxv = v;
        rxm = m;
        rxd = {$urandom, $urandom};
    endtask

    initial begin
        model_clear();
        repeat (3) tick();
        check("rst_msg", msg_o, LINKINIT_ACTIVE_REQ);
        check("rst_valid", valid_o, 1'b0);
        reset = 1'b1;
        tick();

        // Zero-wait sideband, prompt partner.
        enable_i = 1'b1;
        drive(1, 0, SB_MSG_NONE);
        tick();
        check("lat_pulse1", pulse_o, 1'b1);
        check("lat_req", msg_o, LINKINIT_ACTIVE_REQ);
        check("lat_req_v", valid_o, 1'b1);
        drive(1, 1, LINKINIT_ACTIVE_REQ);
        tick();
        check("lat_pulse0", pulse_o, 1'b0);
        check("lat_req_gone", valid_o, 1'b0);
        drive(1, 0, SB_MSG_NONE);
        tick();
        check("lat_resp", msg_o, LINKINIT_ACTIVE_RESP);
        check("lat_resp_v", valid_o, 1'b1);
        drive(1, 1, LINKINIT_ACTIVE_RESP);
        tick();
        check("lat_done_c4", done_o, 1'b0);
        drive(1, 0, SB_MSG_NONE);
        tick();
        check("lat_done_c5", done_o, 1'b1);
        check("lat_rxreq", rxreq_o, 1'b0);
        repeat (3) tick();
        check("lat_done_hold", done_o, 1'b1);
        check("lat_tmo", timeout_o, 1'b0);
        enable_i = 1'b0;
        tick();
        check("drop_done", done_o, 1'b0);
        check("drop_valid", valid_o, 1'b0);

        // Stalled REQ with unexpected traffic until timeout.
        enable_i = 1'b1;
        drive(0, 1, MBTRAIN_DONE_REQ);
        tick();
        for (int k = 1; k <= T - 2; k++) begin
            tick();
`ifdef LINKINIT_ERRCNT_EN
            if (k == 254) check("err_fe", errcnt_o, 8'hFE);
            if (k == 255) check("err_ff", errcnt_o, 8'hFF);
`endif
        end
        check("tmo_before", timeout_o, 1'b0);
        check("stall_valid", valid_o, 1'b1);
        check("stall_msg", msg_o, LINKINIT_ACTIVE_REQ);
`ifdef LINKINIT_ERRCNT_EN
        check("err_sat", errcnt_o, 8'hFF);
`endif
        tick();
        check("tmo_at", timeout_o, 1'b1);
        check("tmo_valid", valid_o, 1'b0);
        check("tmo_rxreq", rxreq_o, 1'b0);
        repeat (4) tick();
        check("tmo_hold", timeout_o, 1'b1);
        check("tmo_nodone", done_o, 1'b0);
        enable_i = 1'b0;
        drive(0, 0, SB_MSG_NONE);
        tick();
        check("tmo_clr", timeout_o, 1'b0);

        // Early RESP before local REQ is accepted.
        enable_i = 1'b1;
        drive(0, 1, LINKINIT_ACTIVE_RESP);
        tick();
        tick();
        drive(1, 0, SB_MSG_NONE);
        tick();
`ifdef LINKINIT_ERRCNT_EN
        check("early_err", errcnt_o, 8'h01);
`endif
        drive(1, 1, LINKINIT_ACTIVE_REQ);
        tick();
        drive(1, 0, SB_MSG_NONE);
        tick();
        tick();
        check("early_nodone", done_o, 1'b0);
        drive(1, 1, LINKINIT_ACTIVE_RESP);
        tick();
        drive(1, 0, SB_MSG_NONE);
        tick();
        check("early_done", done_o, 1'b1);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        tick();
        check("reraise_pulse", pulse_o, 1'b1);
        check("reraise_req", valid_o, 1'b1);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            int len, ps, pr, r;
            SB_msg_t m;
            enable_i = 1'b1;
            len = $urandom_range(5, 420);
            ps  = $urandom_range(10, 100);
            pr  = $urandom_range(0, 60);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 9);
                m = (r < 4) ? LINKINIT_ACTIVE_REQ :
                    (r < 8) ? LINKINIT_ACTIVE_RESP : MBTRAIN_DONE_RESP;
                drive($urandom_range(0, 99) < ps,
                      $urandom_range(0, 99) < pr, m);
                tick();
            end
            enable_i = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
